controle_portao: RTL and testbench
==================================

Name: controle_portao

Overview:
Motor sequencer for the sliding-gate board. It takes a single pushbutton, two limit switches and an obstacle sensor, and drives motor enable, direction, status LEDs and a 7-segment state code. It sits between the raw SW inputs and the motor driver, and is instantiated from the board top `maquina`.

Parameters:
CICLOS_CURSO, 500_000_000, max clock cycles allowed for one full travel before fault (10 s at 50 MHz)
CICLOS_ABERTO, 250_000_000, cycles the gate stays open before auto-close (only used with AUTO_FECHA_EN)
LARG_CONT, 29, timer width; must satisfy 2**LARG_CONT > max(CICLOS_CURSO, CICLOS_ABERTO)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
botao  in  1  raw pushbutton, asynchronous to clock, 1 = pressed
fim_aberto  in  1  open limit switch, async, 1 = fully open
fim_fechado  in  1  closed limit switch, async, 1 = fully closed
obstaculo  in  1  photocell, async, 1 = beam blocked
motor_en  out  1  1 = motor powered
sentido  out  1  1 = opening, 0 = closing; forced 0 when motor_en = 0
led_verde  out  1  1 while FECHANDO, or in ERRO
led_vermelho  out  1  1 while ABRINDO, or in ERRO
display  out  7  active-low segments {g,f,e,d,c,b,a}
estado  out  3  current state code, for debug

Behaviour:
- Reset: clock and reset_n as decided (one clock; asynchronous active-low reset).
  - While reset_n = 0: state = FECHADO, timer = 0, ultimo_sentido = 0 and all synchronizer flops = 0.
  - Outputs during reset: motor_en = 0, sentido = 0, both LEDs 0, display = F.
  - Reset asserted mid-travel stops the motor immediately. All outputs are decoded combinationally from the state register.
- Input conditioning:
  - Every async input passes through a 2-flop synchronizer.
  - botao additionally gets a rising-edge detect, giving a one-cycle pulse `pedido`.
  - botao sampled high at edge k gives pedido high in the cycle after edge k+1; the state changes at edge k+2.
  - Holding botao yields exactly one pedido.
- States and encoding: FECHADO = 0, ABRINDO = 1, ABERTO = 2, FECHANDO = 3, PARADO = 4, ERRO = 5. Codes 6 and 7 go to ERRO.
- Transition priority, highest first:
  1. fim_aberto_s & fim_fechado_s (sensor fault), from any state except ERRO -> ERRO
  2. limit switch or timeout
  3. obstaculo
  4. pedido
- FECHADO: pedido -> ABRINDO.
- ABRINDO:
  - fim_aberto_s -> ABERTO.
  - timer == CICLOS_CURSO-1 -> ERRO.
  - pedido -> PARADO, with ultimo_sentido <= 1.
  - obstaculo is ignored while opening.
- ABERTO:
  - pedido -> FECHANDO.
  - With AUTO_FECHA_EN only: timer == CICLOS_ABERTO-1 and obstaculo_s = 0 -> FECHANDO.
- FECHANDO:
  - fim_fechado_s -> FECHADO.
  - timeout -> ERRO.
  - obstaculo_s -> ABRINDO (reversal).
  - pedido -> PARADO, with ultimo_sentido <= 0.
- PARADO: pedido -> ABRINDO if ultimo_sentido = 0, else FECHANDO.
- ERRO: exits only on reset_n.
- Timer:
  - Clears to 0 on every state change.
  - Increments each cycle in ABRINDO, FECHANDO and ABERTO; holds 0 in all other states.
  - Saturates at all ones; it never wraps.
- Outputs per state (motor_en / sentido / display):
  - FECHADO: 0/0, 7'b0001110 "F".
  - ABRINDO: 1/1, 7'b1000000.
  - ABERTO: 0/0, 7'b0001000 "A".
  - FECHANDO: 1/0, 7'b1000000.
  - PARADO: 0/0, 7'b0001100 "P".
  - ERRO: 0/0, 7'b0000110 "E".

Optional Feature:
CONTROLE_PORTAO_AUTO_FECHA_EN
- Defined: the ABERTO dwell timer is active. Expiry closes the gate unless obstaculo_s = 1; while blocked, the state holds at the expiry value until the beam clears.
- Undefined: ABERTO is left only by pedido or the sensor fault, and CICLOS_ABERTO is unused.

Decomposition:
- Package controle_portao_pkg: state enum (3-bit), display constants SEG_F, SEG_A, SEG_P, SEG_E, SEG_MOV.
- Sub-module sincronizador: 2-flop sync with optional rising-edge output, parameterized by edge enable. Four instances: botao (edge), fim_aberto, fim_fechado, obstaculo.

Test Plan:
All scenarios use CICLOS_CURSO = 20 and CICLOS_ABERTO = 10.
1. Full cycle: reset, pulse botao, fim_aberto high after 8 cycles.
   - Required: motor_en = 1, sentido = 1 at edge 2 after sample; state ABERTO, display 7'b0001000.
   - Then pulse botao, assert fim_fechado: FECHANDO (led_verde = 1), then FECHADO.
2. Stop and resume: while ABRINDO, pulse botao.
   - Required: PARADO, motor_en = 0, display "P".
   - Pulse again -> FECHANDO (sentido = 0).
3. Obstacle: in FECHANDO, set obstaculo = 1 -> ABRINDO within 3 cycles (2 sync + 1), timer restarts at 0.
4. Timeout: ABRINDO with no limit switch -> ERRO exactly 20 cycles after entry. Both LEDs on, botao ignored; reset_n low returns to FECHADO.
5. Fault and priority:
   - fim_aberto = fim_fechado = 1 in FECHADO -> ERRO.
   - pedido in the same cycle as fim_fechado_s during FECHANDO -> FECHADO (limit wins).
6. With CONTROLE_PORTAO_AUTO_FECHA_EN:
   - ABERTO -> FECHANDO after 10 cycles.
   - With obstaculo = 1 held, it stays ABERTO until release.

Source files
------------

// File: rtl/controle_portao_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controle_portao_pkg
// Description : Shared types and constants for the sliding-gate sequencer:
//               3-bit state encoding and active-low 7-segment codes
//               ({g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
package controle_portao_pkg;

    typedef enum logic [2:0] {
        FECHADO  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTO   = 3'd2,
        FECHANDO = 3'd3,
        PARADO   = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_P   = 7'b0001100;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_MOV = 7'b1000000;

endpackage
`default_nettype wire

// File: rtl/sincronizador.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador
// Description : Two-flop synchronizer for one asynchronous input. With
//               BORDA_EN = 1 the output is a one-cycle pulse on the rising
//               edge of the synchronized level; otherwise it is the level.
// Ports       : clock   - system clock
//               reset_n - asynchronous active-low reset (clears all flops)
//               entrada - asynchronous input
//               saida   - synchronized level or rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador #(
    parameter bit BORDA_EN = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic entrada,
    output logic saida
);

    logic [1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], entrada};
        end
    end

    generate
        if (BORDA_EN) begin : g_borda
            logic r_anterior;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_anterior <= 1'b0;
                end else begin
                    r_anterior <= r_sync[1];
                end
            end

            // High only in the first cycle the synchronized level is 1, so a
            // held button produces a single request.
            assign saida = r_sync[1] & ~r_anterior;
        end else begin : g_nivel
            assign saida = r_sync[1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/controle_portao.sv
`default_nettype none
// ============================================================================
// Module      : controle_portao
// Description : Sliding-gate motor sequencer. One pushbutton steps the gate
//               through open / stop / close; limit switches end travel, the
//               photocell reverses a closing gate, and a travel watchdog or
//               a contradictory limit-switch pair latches ERRO until reset.
//               Optional auto-close from ABERTO: define
//               CONTROLE_PORTAO_AUTO_FECHA_EN.
// Ports       : clock, reset_n (async, active-low)
//               botao, fim_aberto, fim_fechado, obstaculo - async inputs
//               motor_en, sentido       - motor driver controls
//               led_verde, led_vermelho - status LEDs
//               display                 - active-low {g,f,e,d,c,b,a}
//               estado                  - current state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module controle_portao
    import controle_portao_pkg::*;
#(
    parameter int unsigned CICLOS_CURSO  = 500_000_000,
    parameter int unsigned CICLOS_ABERTO = 250_000_000,
    parameter int          LARG_CONT     = 29
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       botao,
    input  logic       fim_aberto,
    input  logic       fim_fechado,
    input  logic       obstaculo,
    output logic       motor_en,
    output logic       sentido,
    output logic       led_verde,
    output logic       led_vermelho,
    output logic [6:0] display,
    output logic [2:0] estado
);

    localparam logic [LARG_CONT-1:0] c_FIM_CURSO  = LARG_CONT'(CICLOS_CURSO - 1);
`ifdef CONTROLE_PORTAO_AUTO_FECHA_EN
    localparam logic [LARG_CONT-1:0] c_FIM_ABERTO = LARG_CONT'(CICLOS_ABERTO - 1);
`endif

    logic                 w_pedido;
    logic                 w_fa_s;
    logic                 w_ff_s;
    logic                 w_obs_s;

    estado_t              r_estado;
    estado_t              w_prox;
    logic [LARG_CONT-1:0] r_timer;
    logic [LARG_CONT-1:0] w_timer_prox;
    logic                 r_ultimo_sentido;
    logic                 w_ultimo_prox;

    sincronizador #(.BORDA_EN(1'b1)) u_sync_botao (
        .clock(clock), .reset_n(reset_n), .entrada(botao), .saida(w_pedido));
    sincronizador #(.BORDA_EN(1'b0)) u_sync_fa (
        .clock(clock), .reset_n(reset_n), .entrada(fim_aberto), .saida(w_fa_s));
    sincronizador #(.BORDA_EN(1'b0)) u_sync_ff (
        .clock(clock), .reset_n(reset_n), .entrada(fim_fechado), .saida(w_ff_s));
    sincronizador #(.BORDA_EN(1'b0)) u_sync_obs (
        .clock(clock), .reset_n(reset_n), .entrada(obstaculo), .saida(w_obs_s));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado         <= FECHADO;
            r_timer          <= '0;
            r_ultimo_sentido <= 1'b0;
        end else begin
            r_estado         <= w_prox;
            r_timer          <= w_timer_prox;
            r_ultimo_sentido <= w_ultimo_prox;
        end
    end

    // Next state. Each case arm lists its conditions in priority order:
    // limit switch / timeout, then obstacle, then button request.
    always_comb begin
        w_prox        = r_estado;
        w_ultimo_prox = r_ultimo_sentido;
        if (w_fa_s && w_ff_s && (r_estado != ERRO)) begin
            // Both limits closed at once can only be a wiring/sensor fault.
            w_prox = ERRO;
        end else begin
            case (r_estado)
                FECHADO: begin
                    if (w_pedido) w_prox = ABRINDO;
                end
                ABRINDO: begin
                    if (w_fa_s)                        w_prox = ABERTO;
                    else if (r_timer == c_FIM_CURSO)   w_prox = ERRO;
                    else if (w_pedido) begin
                        w_prox        = PARADO;
                        w_ultimo_prox = 1'b1;
                    end
                end
                ABERTO: begin
`ifdef CONTROLE_PORTAO_AUTO_FECHA_EN
                    if ((r_timer == c_FIM_ABERTO) && !w_obs_s) w_prox = FECHANDO;
                    else if (w_pedido)                         w_prox = FECHANDO;
`else
                    if (w_pedido) w_prox = FECHANDO;
`endif
                end
                FECHANDO: begin
                    if (w_ff_s)                        w_prox = FECHADO;
                    else if (r_timer == c_FIM_CURSO)   w_prox = ERRO;
                    else if (w_obs_s)                  w_prox = ABRINDO;
                    else if (w_pedido) begin
                        w_prox        = PARADO;
                        w_ultimo_prox = 1'b0;
                    end
                end
                PARADO: begin
                    // Resume opposite to the direction that was interrupted.
                    if (w_pedido) w_prox = r_ultimo_sentido ? FECHANDO : ABRINDO;
                end
                ERRO: begin
                    w_prox = ERRO;
                end
                default: begin
                    w_prox = ERRO;
                end
            endcase
        end
    end

    // Timer: restarts on any state change, counts only in the timed states
    // and saturates instead of wrapping.
    always_comb begin
        w_timer_prox = '0;
        if ((w_prox == r_estado) &&
            ((r_estado == ABRINDO) || (r_estado == FECHANDO) || (r_estado == ABERTO))) begin
            if (r_timer != '1) begin
                w_timer_prox = r_timer + LARG_CONT'(1);
            end else begin
                w_timer_prox = r_timer;
            end
`ifdef CONTROLE_PORTAO_AUTO_FECHA_EN
            // Dwell expired but beam blocked: park at the expiry value so the
            // gate closes as soon as the beam clears.
            if ((r_estado == ABERTO) && (r_timer == c_FIM_ABERTO)) begin
                w_timer_prox = r_timer;
            end
`endif
        end
    end

    always_comb begin
        motor_en     = 1'b0;
        sentido      = 1'b0;
        led_verde    = 1'b0;
        led_vermelho = 1'b0;
        display      = SEG_E;
        case (r_estado)
            FECHADO:  display = SEG_F;
            ABRINDO: begin
                motor_en     = 1'b1;
                sentido      = 1'b1;
                led_vermelho = 1'b1;
                display      = SEG_MOV;
            end
            ABERTO:   display = SEG_A;
            FECHANDO: begin
                motor_en  = 1'b1;
                led_verde = 1'b1;
                display   = SEG_MOV;
            end
            PARADO:   display = SEG_P;
            default: begin
                led_verde    = 1'b1;
                led_vermelho = 1'b1;
                display      = SEG_E;
            end
        endcase
    end

    assign estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_portao.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_portao
// Description : Self-checking bench for controle_portao with short travel
//               (20 cycles) and dwell (10 cycles) limits. Inputs change on
//               the falling edge; outputs are compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_portao;

    localparam logic [2:0] S_FECHADO  = 3'd0;
    localparam logic [2:0] S_ABRINDO  = 3'd1;
    localparam logic [2:0] S_ABERTO   = 3'd2;
    localparam logic [2:0] S_FECHANDO = 3'd3;
    localparam logic [2:0] S_PARADO   = 3'd4;
    localparam logic [2:0] S_ERRO     = 3'd5;

    localparam logic [6:0] D_F = 7'b0001110;
    localparam logic [6:0] D_A = 7'b0001000;
    localparam logic [6:0] D_P = 7'b0001100;
    localparam logic [6:0] D_E = 7'b0000110;
    localparam logic [6:0] D_M = 7'b1000000;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       botao = 1'b0;
    logic       fim_aberto = 1'b0;
    logic       fim_fechado = 1'b0;
    logic       obstaculo = 1'b0;
    logic       motor_en;
    logic       sentido;
    logic       led_verde;
    logic       led_vermelho;
    logic [6:0] display;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    controle_portao #(
        .CICLOS_CURSO (20),
        .CICLOS_ABERTO(10),
        .LARG_CONT    (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .botao       (botao),
        .fim_aberto  (fim_aberto),
        .fim_fechado (fim_fechado),
        .obstaculo   (obstaculo),
        .motor_en    (motor_en),
        .sentido     (sentido),
        .led_verde   (led_verde),
        .led_vermelho(led_vermelho),
        .display     (display),
        .estado      (estado)
    );

    always #5 clock = ~clock;

    // Expected {motor_en, sentido, led_verde, led_vermelho, display} per state.
    function automatic logic [10:0] saida(input logic [2:0] e);
        case (e)
            S_FECHADO:  saida = {4'b0000, D_F};
            S_ABRINDO:  saida = {4'b1101, D_M};
            S_ABERTO:   saida = {4'b0000, D_A};
            S_FECHANDO: saida = {4'b1010, D_M};
            S_PARADO:   saida = {4'b0000, D_P};
            default:    saida = {4'b0011, D_E};
        endcase
    endfunction

    task automatic confere(input string nome, input logic [2:0] e);
        logic [13:0] got;
        logic [13:0] exp;
        got = {estado, motor_en, sentido, led_verde, led_vermelho, display};
        exp = {e, saida(e)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {estado,me,se,lv,lr,disp}=%b expected %b", nome, got, exp);
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One-cycle press; returns on the falling edge after the state update.
    task automatic pulso();
        botao = 1'b1;
        espera(1);
        botao = 1'b0;
        espera(2);
    endtask

    typedef struct {
        logic       b;
        logic       fa;
        logic       ff;
        logic       ob;
        int         n;
        logic [2:0] e;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic b, input logic fa, input logic ff,
                       input logic ob, input int n, input logic [2:0] e);
        vec_t v;
        v.b = b; v.fa = fa; v.ff = ff; v.ob = ob; v.n = n; v.e = e;
        tab.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full cycle: open to limit, close to limit.
        add(0,0,0,0, 1, S_FECHADO);
        add(1,0,0,0, 1, S_FECHADO);
        add(0,0,0,0, 1, S_FECHADO);
        add(0,0,0,0, 1, S_ABRINDO);
        add(0,0,0,0, 5, S_ABRINDO);
        add(0,1,0,0, 1, S_ABRINDO);
        add(0,1,0,0, 1, S_ABRINDO);
        add(0,1,0,0, 1, S_ABERTO);
        add(0,0,0,0, 2, S_ABERTO);
        add(1,0,0,0, 1, S_ABERTO);
        add(0,0,0,0, 1, S_ABERTO);
        add(0,0,0,0, 1, S_FECHANDO);
        add(0,0,1,0, 2, S_FECHANDO);
        add(0,0,1,0, 1, S_FECHADO);
        add(0,0,0,0, 2, S_FECHADO);
        // Stop while opening, resume closes.
        add(1,0,0,0, 1, S_FECHADO);
        add(0,0,0,0, 1, S_FECHADO);
        add(0,0,0,0, 1, S_ABRINDO);
        add(0,0,0,0, 2, S_ABRINDO);
        add(1,0,0,0, 1, S_ABRINDO);
        add(0,0,0,0, 1, S_ABRINDO);
        add(0,0,0,0, 1, S_PARADO);
        add(0,0,0,0, 3, S_PARADO);
        add(1,0,0,0, 1, S_PARADO);
        add(0,0,0,0, 1, S_PARADO);
        add(0,0,0,0, 1, S_FECHANDO);
        // Obstacle reverses; obstacle ignored while opening.
        add(0,0,0,0, 3, S_FECHANDO);
        add(0,0,0,1, 2, S_FECHANDO);
        add(0,0,0,1, 1, S_ABRINDO);
        add(0,0,0,1, 2, S_ABRINDO);
        add(0,0,0,0, 2, S_ABRINDO);
        // Timeout exactly 20 cycles after entering ABRINDO (timer restarted).
        add(0,0,0,0, 14, S_ABRINDO);
        add(0,0,0,0, 1, S_ABRINDO);
        add(0,0,0,0, 1, S_ERRO);
        // Button ignored in ERRO.
        add(1,0,0,0, 1, S_ERRO);
        add(0,0,0,0, 3, S_ERRO);

        espera(2);
        confere("reset_hold", S_FECHADO);
        reset_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            botao       = tab[i].b;
            fim_aberto  = tab[i].fa;
            fim_fechado = tab[i].ff;
            obstaculo   = tab[i].ob;
            espera(tab[i].n);
            confere($sformatf("vec%0d", i), tab[i].e);
        end

        // Asynchronous reset leaves ERRO without a clock edge.
        reset_n = 1'b0;
        #1;
        confere("reset_from_erro", S_FECHADO);
        espera(1);
        reset_n = 1'b1;
        espera(1);
        confere("after_reset", S_FECHADO);

        // Both limit switches active: sensor fault.
        fim_aberto  = 1'b1;
        fim_fechado = 1'b1;
        espera(2);
        confere("fault_sync_delay", S_FECHADO);
        espera(1);
        confere("fault_erro", S_ERRO);
        fim_aberto  = 1'b0;
        fim_fechado = 1'b0;
        reset_n = 1'b0;
        espera(1);
        reset_n = 1'b1;
        espera(1);

        // Limit switch beats a simultaneous request while closing.
        pulso();
        confere("prio_abrindo", S_ABRINDO);
        pulso();
        confere("prio_parado", S_PARADO);
        pulso();
        confere("prio_fechando", S_FECHANDO);
        botao       = 1'b1;
        fim_fechado = 1'b1;
        espera(3);
        confere("limit_wins", S_FECHADO);
        botao       = 1'b0;
        fim_fechado = 1'b0;
        espera(3);

        // A held button yields one request only.
        botao = 1'b1;
        espera(3);
        confere("hold_opens", S_ABRINDO);
        espera(8);
        confere("hold_single_request", S_ABRINDO);
        botao = 1'b0;

        // Reset mid-travel stops the motor immediately.
        reset_n = 1'b0;
        #1;
        confere("reset_mid_travel", S_FECHADO);
        espera(1);
        reset_n = 1'b1;
        espera(1);

        pulso();
        fim_aberto = 1'b1;
        espera(3);
        confere("dwell_entry", S_ABERTO);
        fim_aberto = 1'b0;
`ifdef CONTROLE_PORTAO_AUTO_FECHA_EN
        espera(9);
        confere("dwell_9", S_ABERTO);
        espera(1);
        confere("auto_close", S_FECHANDO);
        obstaculo = 1'b1;
        espera(3);
        confere("auto_reverse", S_ABRINDO);
        fim_aberto = 1'b1;
        espera(3);
        confere("auto_reopen", S_ABERTO);
        fim_aberto = 1'b0;
        espera(15);
        confere("auto_blocked", S_ABERTO);
        obstaculo = 1'b0;
        espera(2);
        confere("auto_release_sync", S_ABERTO);
        espera(1);
        confere("auto_release_close", S_FECHANDO);
`else
        espera(15);
        confere("no_auto_close", S_ABERTO);
        pulso();
        confere("manual_close", S_FECHANDO);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
